// File: rtl/grn_clt_gen.sv
// Central-limit Gaussian sample generator: six xorshift32 lanes give twelve 15-bit
// uniforms, which a three-stage adder tree turns into one signed 17.15 sample per enable.
module grn_clt_gen (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        seed_load_i,
  input  logic [31:0] seed_i,
  input  logic        en_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  output logic [31:0] sample_cnt_o
);

  localparam logic [31:0] SEED_C [6] = '{32'h2545F491, 32'h9E3779B9, 32'h85EBCA6B,
                                         32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1};
  localparam logic [31:0] OFFSET_SIX = 32'd196608;

  logic [31:0] x_q [6];
  logic [31:0] x_d [6];
  logic [15:0] p_q [6];
  logic [15:0] p_d [6];
  logic [16:0] q_q [3];
  logic [16:0] q_d [3];
  logic        v0_q, v1_q, v2_q, v0_d;
  logic [18:0] r_sum;
  logic [31:0] dout_q, dout_d;
  logic        valid_q;
  logic [31:0] cnt_q, cnt_d;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      x_d[i] = x_q[i];
      // A zero state would lock a lane at zero forever, so fall back to the constant.
      if (seed_load_i)
        x_d[i] = ((seed_i ^ SEED_C[i]) == 32'd0) ? SEED_C[i] : (seed_i ^ SEED_C[i]);
      else if (en_i)
        x_d[i] = xs(x_q[i]);
      p_d[i] = {1'b0, x_q[i][14:0]} + {1'b0, x_q[i][30:16]};
    end
    q_d[0] = {1'b0, p_q[0]} + {1'b0, p_q[1]};
    q_d[1] = {1'b0, p_q[2]} + {1'b0, p_q[3]};
    q_d[2] = {1'b0, p_q[4]} + {1'b0, p_q[5]};
    v0_d   = en_i & ~seed_load_i;
    r_sum  = {2'b00, q_q[0]} + {2'b00, q_q[1]} + {2'b00, q_q[2]};
    // r_sum < 2^19, so the 32-bit wraparound subtraction is already sign-extended.
    dout_d = v2_q ? ({13'd0, r_sum} - OFFSET_SIX) : dout_q;
    cnt_d  = cnt_q;
    if (seed_load_i)
      cnt_d = 32'd0;
    else if (valid_q && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 6; i++) begin
        x_q[i] <= SEED_C[i];
        p_q[i] <= 16'd0;
      end
      for (int j = 0; j < 3; j++) q_q[j] <= 17'd0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      dout_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        x_q[i] <= x_d[i];
        p_q[i] <= p_d[i];
      end
      for (int j = 0; j < 3; j++) q_q[j] <= q_d[j];
      v0_q    <= v0_d;
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      dout_q  <= dout_d;
      valid_q <= v2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_grn_clt_gen.sv
// Directed bench for grn_clt_gen: a cycle model of the seeded xorshift lanes and the
// four-edge pipeline predicts every output, plus a handful of hand-computed vectors.
module tb_grn_clt_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [31:0] seed;
  logic        en;
  logic [31:0] dout;
  logic        dout_valid;
  logic [31:0] sample_cnt;

  localparam logic [31:0] C0 = 32'h2545F491, C1 = 32'h9E3779B9, C2 = 32'h85EBCA6B,
                          C3 = 32'hC2B2AE35, C4 = 32'h27D4EB2F, C5 = 32'h165667B1;

  grn_clt_gen dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .seed_load_i  (seed_load),
    .seed_i       (seed),
    .en_i         (en),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .sample_cnt_o (sample_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mc [6];
  logic [31:0] mx [6];
  logic        mv [3];
  logic [31:0] ms [3];
  logic        m_vout;
  logic [31:0] m_dout;
  logic [31:0] m_cnt;

  logic stat_on = 1'b0;
  real  s_sum = 0.0;
  real  s_sq  = 0.0;
  int   s_n   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] m_xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [31:0] m_sample();
    int acc;
    acc = 0;
    for (int i = 0; i < 6; i++)
      acc += int'(mx[i][14:0]) + int'(mx[i][30:16]);
    return 32'(acc - 196608);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mx[i] = mc[i];
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0;
      ms[k] = 32'd0;
    end
    m_vout = 1'b0;
    m_dout = 32'd0;
    m_cnt  = 32'd0;
  endtask

  task automatic model_edge(input logic sl, input logic [31:0] sd, input logic e);
    if (sl) m_cnt = 32'd0;
    else if (m_vout && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    m_vout = mv[2];
    if (mv[2]) m_dout = ms[2];
    mv[2] = mv[1]; ms[2] = ms[1];
    mv[1] = mv[0]; ms[1] = ms[0];
    if (sl) begin
      for (int i = 0; i < 6; i++) mx[i] = ((sd ^ mc[i]) == 32'd0) ? mc[i] : (sd ^ mc[i]);
      mv[0] = 1'b0;
    end else if (e) begin
      for (int i = 0; i < 6; i++) mx[i] = m_xs(mx[i]);
      mv[0] = 1'b1;
      ms[0] = m_sample();
    end else begin
      mv[0] = 1'b0;
    end
  endtask

  // Called 1 time unit after a rising edge; drives inputs, crosses one edge, checks.
  task automatic cyc(input logic sl, input logic [31:0] sd, input logic e);
    logic in_range;
    real  v;
    seed_load = sl;
    seed      = sd;
    en        = e;
    @(posedge clk);
    #1;
    model_edge(sl, sd, e);
    check_eq("dout_valid", {31'd0, dout_valid}, {31'd0, m_vout});
    check_eq("dout", dout, m_dout);
    check_eq("sample_cnt", sample_cnt, m_cnt);
    if (dout_valid) begin
      in_range = ($signed(dout) >= -32'sd196608) && ($signed(dout) <= 32'sd196596);
      check_eq("range", {31'd0, in_range}, 32'd1);
      if (stat_on) begin
        v = $itor($signed(dout)) / 32768.0;
        s_sum += v;
        s_sq  += v * v;
        s_n++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0);
  endtask

  task automatic run_en(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [8:0] vbits;
    real mean, var_est;
    logic ok;

    mc[0] = C0; mc[1] = C1; mc[2] = C2; mc[3] = C3; mc[4] = C4; mc[5] = C5;
    model_reset();
    reset = 1'b1; seed_load = 1'b0; seed = 32'd0; en = 1'b0;
    #12;
    check_eq("rst_dout", dout, 32'd0);
    check_eq("rst_valid", {31'd0, dout_valid}, 32'd0);
    check_eq("rst_cnt", sample_cnt, 32'd0);
    reset = 1'b0;
    #4; // now 1 unit after the edge at t=15
    check_eq("rst_x0", dut.x_q[0], C0);
    check_eq("rst_x3", dut.x_q[3], C3);
    check_eq("rst_x5", dut.x_q[5], C5);

    // en on cycles 0,1,3 -> valid after edges 3,4,6 only
    vbits = '0;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, 32'd0, (k == 0 || k == 1 || k == 3));
      vbits[k] = dout_valid;
    end
    check_eq("lat_pattern", {23'd0, vbits}, 32'h0000_0058);
    check_eq("lat_cnt", sample_cnt, 32'd3);

    // reset mid-cycle with en high; no in-flight sample survives
    run_en(3);
    en = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst_dout", dout, 32'd0);
    check_eq("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check_eq("mid_rst_cnt", sample_cnt, 32'd0);
    check_eq("mid_rst_x1", dut.x_q[1], C1);
    @(posedge clk);
    #3 reset = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 32'd0, 1'b1);
    idle(2);
    check_eq("post_rst_novalid", {31'd0, dout_valid}, 32'd0);
    idle(3);

    // determinism: same seed twice, then seed 0 reproduces the post-reset sequence
    cyc(1'b1, 32'h1234_5678, 1'b0);
    check_eq("seed_x0", dut.x_q[0], 32'h3771_A2E9);
    run_en(1000);
    idle(4);
    check_eq("seed_cnt1000", sample_cnt, 32'd1000);
    cyc(1'b1, 32'h1234_5678, 1'b0);
    run_en(1000);
    idle(4);
    cyc(1'b1, 32'h0000_0000, 1'b0);
    check_eq("seed0_x2", dut.x_q[2], C2);
    run_en(100);
    idle(4);

    // zero-state guard: seed == C3 makes lane 3 fall back to C3
    cyc(1'b1, C3, 1'b0);
    check_eq("zg_x3", dut.x_q[3], C3);
    check_eq("zg_x0", dut.x_q[0], 32'hE7F7_5AA4);
    run_en(200);
    idle(4);
    ok = (dut.x_q[3] != 32'd0);
    check_eq("zg_nonzero", {31'd0, ok}, 32'd1);

    // statistics over a shorter deterministic run
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    stat_on = 1'b1;
    run_en(20000);
    idle(4);
    stat_on = 1'b0;
    check_eq("stat_cnt", sample_cnt, 32'd20000);
    mean    = (s_n > 0) ? s_sum / s_n : 99.0;
    var_est = (s_n > 0) ? (s_sq / s_n) - mean * mean : 99.0;
    ok = (mean < 0.05) && (mean > -0.05);
    check_eq("stat_mean", {31'd0, ok}, 32'd1);
    ok = (var_est > 0.95) && (var_est < 1.05);
    check_eq("stat_var", {31'd0, ok}, 32'd1);

    // seed_load beats en; three in-flight samples still emerge and are counted
    run_en(5);
    cyc(1'b1, 32'h0BAD_F00D, 1'b1);
    idle(4);
    check_eq("prio_cnt", sample_cnt, 32'd3);
    idle(2);
    check_eq("prio_novalid", {31'd0, dout_valid}, 32'd0);

    // saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    #2;
    check_eq("sat_preset", sample_cnt, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    model_edge(1'b0, 32'd0, 1'b0);
    run_en(3);
    idle(5);
    check_eq("sat_hold", sample_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
